// File: rtl/cv32e41p_fetch_fifo.sv
// cv32e41p_fetch_fifo
// Circular-buffer instruction fetch FIFO between the OBI prefetch controller
// and the instruction aligner. Any DEPTH from 2 to 8 is legal; the pointers
// wrap modulo DEPTH, so the depth does not need to be a power of two.
// Optional feature: define CV32E41P_FETCH_FIFO_BYPASS_EN to pass a word
// straight through when the FIFO is empty (zero-latency path).
// Optional checking: define CV32E41P_ASSERT_ON to flag in_valid_i while full.
module cv32e41p_fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush_i,
   input  logic             in_valid_i,
   input  logic [31:0]      in_rdata_i,
   output logic             in_ready_o,
   output logic             out_valid_o,
   output logic [31:0]      out_rdata_o,
   input  logic             out_ready_i,
   output logic [CNT_W-1:0] cnt_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [31:0]      r_mem [DEPTH];
   logic [PTR_W-1:0] r_rptr;
   logic [PTR_W-1:0] r_wptr;
   logic [CNT_W-1:0] r_cnt;

   logic             w_empty;
   logic             w_full;
   logic             w_byp_show;
   logic             w_bypass_take;
   logic             w_push;
   logic             w_pop;
   logic [PTR_W-1:0] w_rptr_inc;
   logic [PTR_W-1:0] w_wptr_inc;

   assign w_empty = (r_cnt == '0);
   assign w_full  = (r_cnt == FULL_CNT);

`ifdef CV32E41P_FETCH_FIFO_BYPASS_EN
   // When empty, an incoming word is shown to the aligner immediately; if the
   // aligner takes it in the same cycle it never touches storage.
   assign w_byp_show    = w_empty & in_valid_i & ~flush_i;
   assign w_bypass_take = w_byp_show & out_ready_i;
`else
   assign w_byp_show    = 1'b0;
   assign w_bypass_take = 1'b0;
`endif

   // Ready depends only on registered occupancy; a pop in the same cycle
   // does not make room for a push.
   assign in_ready_o  = ~w_full;
   assign cnt_o       = r_cnt;
   assign out_valid_o = (~w_empty & ~flush_i) | w_byp_show;
   assign out_rdata_o = w_byp_show ? in_rdata_i : r_mem[r_rptr];

   assign w_push = in_valid_i & ~w_full & ~flush_i & ~w_bypass_take;
   assign w_pop  = out_valid_o & out_ready_i & ~flush_i & ~w_empty;

   // Modulo-DEPTH pointer increment (explicit wrap, not masking)
   assign w_rptr_inc = (r_rptr == LAST_PTR) ? '0 : r_rptr + PTR_W'(1);
   assign w_wptr_inc = (r_wptr == LAST_PTR) ? '0 : r_wptr + PTR_W'(1);

   // Pointer and occupancy update; flush drops everything including this
   // cycle's incoming word.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rptr <= '0;
         r_wptr <= '0;
         r_cnt  <= '0;
      end else if (flush_i) begin
         r_rptr <= '0;
         r_wptr <= '0;
         r_cnt  <= '0;
      end else begin
         if (w_push) r_wptr <= w_wptr_inc;
         if (w_pop)  r_rptr <= w_rptr_inc;
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + CNT_W'(1);
            2'b01:   r_cnt <= r_cnt - CNT_W'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   // Word storage; cleared on reset so the empty head reads as zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (w_push) begin
         r_mem[r_wptr] <= in_rdata_i;
      end
   end

`ifdef CV32E41P_ASSERT_ON
   // Upstream must not present a word while the FIFO is full; it is dropped.
   always_ff @(posedge clk) begin
      if (!rst && !flush_i) begin
         assert (!(in_valid_i && w_full))
            else $warning("fetch_fifo: in_valid_i asserted while full, word dropped");
      end
   end
`endif

endmodule

// File: doc/cv32e41p_fetch_fifo.md
# cv32e41p_fetch_fifo

Instruction fetch FIFO sitting directly upstream of the instruction aligner in the IF stage. It buffers 32-bit fetch words returned by the OBI prefetch controller and presents them in order to the aligner as `fetch_valid`/`fetch_rdata`. It pops only when the aligner is ready and the IF stage advances, and it discards all contents on a branch or jump. It also reports its occupancy so the prefetch controller can limit outstanding transactions.

## Interface

Parameters:
- `DEPTH`, default 2: number of 32-bit entries; legal range 2..8.
- `CNT_W`, default `$clog2(DEPTH+1)`: width of the occupancy count. Derived; never overridden.

Ports (reset is synchronous and active-high):
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous active-high reset.
- `flush_i`  in  1  branch/jump taken; empties the FIFO.
- `in_valid_i`  in  1  fetch word from the prefetch controller is valid.
- `in_rdata_i`  in  32  fetch word.
- `in_ready_o`  out  1  FIFO can accept a word this cycle.
- `out_valid_o`  out  1  head word valid; feeds the aligner's `fetch_valid_i`.
- `out_rdata_o`  out  32  head word; feeds the aligner's `fetch_rdata_i`.
- `out_ready_i`  in  1  consumer pop request; the aligner's `aligner_ready_o & if_valid_i`.
- `cnt_o`  out  CNT_W  current number of stored entries.

## Operation

- Storage is a circular buffer of `DEPTH` 32-bit words, with read pointer `rptr`, write pointer `wptr` and count `cnt`.
- Pointers wrap from `DEPTH-1` to 0. Wrap is modulo `DEPTH`, not power-of-two masking, so non-power-of-two depths are legal.
- `in_ready_o = (cnt != DEPTH)`. A push is never accepted while full, even if a pop happens in the same cycle.
- Push: `in_valid_i & in_ready_o & !flush_i & !bypass_take`. The word is written at `wptr`, then `wptr` advances.
- Pop: `out_valid_o & out_ready_i & !flush_i & (cnt != 0)`. `rptr` advances.
- Count: `cnt_next = cnt + push - pop`. Push and pop in the same cycle leave `cnt` unchanged.
- Head output: `out_valid_o = (cnt != 0) & !flush_i`, and `out_rdata_o = mem[rptr]`. When empty, `out_rdata_o` equals the stale `mem[rptr]` and is don't-care.
- `bypass_take` is defined under Configuration. It is 0 when the bypass feature is compiled out.
- Flush:
  - `rptr`, `wptr` and `cnt` clear to 0.
  - An `in_valid_i` word in the same cycle is dropped, because it belongs to the old stream.
  - `out_valid_o` is forced to 0 in that cycle.
- Reset:
  - `rptr`, `wptr` and `cnt` clear to 0, and all `mem` entries clear to 0.
  - Output reset values: `out_valid_o=0`, `out_rdata_o=0`, `in_ready_o=1`, `cnt_o=0`.
- Reset has priority over flush. Flush has priority over push and pop.
- An `in_valid_i` while `in_ready_o=0` is a protocol error from upstream and is ignored (no write). The assertion macro `CV32E41P_ASSERT_ON` flags it.

## Timing

- Bypass compiled out:
  - A word pushed at edge N is visible on `out_valid_o`/`out_rdata_o` in cycle N+1.
  - Minimum latency is 1 cycle.
  - Steady-state throughput is 1 word/cycle with `DEPTH>=2`.
- Bypass compiled in:
  - With an empty FIFO, a valid input is presented on the outputs in the same cycle (0 latency).
- A pop at edge N exposes the next head in cycle N+1.
- `in_ready_o` and `cnt_o` are registered-state functions with no combinational path from `out_ready_i`.
- With bypass compiled out, `out_valid_o` and `out_rdata_o` have no combinational path from `in_valid_i`/`in_rdata_i`.
- A flush in cycle N means:
  - the outputs are invalid in cycle N;
  - the FIFO is empty in cycle N+1;
  - the first post-branch word can be pushed in cycle N+1.

## Configuration

- Macro: `CV32E41P_FETCH_FIFO_BYPASS_EN`.
- Defined:
  - When `cnt==0 & in_valid_i & !flush_i`: `out_valid_o=1` and `out_rdata_o=in_rdata_i`.
  - `bypass_take = cnt==0 & in_valid_i & out_ready_i & !flush_i`. When it is 1, the word is consumed directly and not stored.
  - If `out_ready_i=0`, the word is pushed normally.
- Undefined:
  - No input-to-output combinational path.
  - `bypass_take=0`.
  - All words go through storage.

## Test plan

- Reset, then idle: `out_valid_o=0`, `in_ready_o=1`, `cnt_o=0` for 10 cycles.
- Bypass off, `DEPTH=2`:
  - Push 0x00000013 at edge 1 with `out_ready_i=0` → `out_valid_o=1`, `out_rdata_o=0x00000013`, `cnt_o=1` in cycle 2.
  - Push 0x00100093 → `cnt_o=2`, `in_ready_o=0`.
  - A third `in_valid_i` is not stored.
- Full FIFO, `out_ready_i=1` and `in_valid_i=1` in the same cycle → pop only; `cnt_o` goes 2→1; the head becomes 0x00100093.
- Two entries stored, then `flush_i=1` with `in_valid_i=1` (0xDEADBEEF) → `out_valid_o=0` in that cycle; `cnt_o=0` next cycle; 0xDEADBEEF is never output.
- `DEPTH=3`: stream 7 words with random `out_ready_i` → in-order output, pointers wrap 2→0, no loss or duplication.
- Bypass on, empty FIFO, `in_valid_i=1` (0x4501) with `out_ready_i=1` → `out_valid_o=1` and `out_rdata_o=0x4501` in the same cycle; `cnt_o` stays 0.
